// File: rtl/var_bw_mul_sched.sv
// var_bw_mul_sched: two-requester scheduler in front of one shared variable
// bit-width multiplier (one 16x16 or two parallel 8x8 products). Pairs of
// 8-bit requests are packed into a single parallel-mode issue. Products land in
// per-requester response slots that apply valid/ready backpressure.
module var_bw_mul_sched #(
  parameter int TAG_W   = 4,
  parameter bit PAIR_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_w8,
  input  logic [1:0][15:0]      req_a,
  input  logic [1:0][15:0]      req_b,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic                  mul_para_mode,
  output logic [15:0]           mul_a,
  output logic [15:0]           mul_b,
  input  logic [31:0]           mul_p,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [1:0][31:0]      rsp_p,
  output logic [1:0][TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0]      cnt_pair,
  output logic [CNT_W-1:0]      cnt_single
);

  typedef enum logic [1:0] {
    ISSUE_IDLE,
    ISSUE_SINGLE,
    ISSUE_PAIR
  } issue_e;

  issue_e                  issue_kind;
  logic [1:0]              slot_free;
  logic [1:0]              eligible;
  logic [1:0]              grant;
  logic                    single_sel;

  logic                    rr_ptr_q,      rr_ptr_d;
  logic [1:0]              rsp_valid_q,   rsp_valid_d;
  logic [1:0][31:0]        rsp_p_q,       rsp_p_d;
  logic [1:0][TAG_W-1:0]   rsp_tag_q,     rsp_tag_d;
  logic [CNT_W-1:0]        cnt_pair_q,    cnt_pair_d;
  logic [CNT_W-1:0]        cnt_single_q,  cnt_single_d;

  // Issue decision: pack two 8-bit requests, else round-robin one, else idle with zeroed operands
  always_comb begin
    slot_free     = ~rsp_valid_q | rsp_ready;
    eligible      = rst_n ? (req_valid & slot_free) : 2'b00;
    grant         = 2'b00;
    issue_kind    = ISSUE_IDLE;
    single_sel    = 1'b0;
    mul_para_mode = 1'b0;
    mul_a         = '0;
    mul_b         = '0;
    if (PAIR_EN && (eligible == 2'b11) && (req_w8 == 2'b11)) begin
      issue_kind    = ISSUE_PAIR;
      grant         = 2'b11;
      mul_para_mode = 1'b1;
      mul_a         = {req_a[1][7:0], req_a[0][7:0]};
      mul_b         = {req_b[1][7:0], req_b[0][7:0]};
    end else if (eligible != 2'b00) begin
      issue_kind = ISSUE_SINGLE;
      if (eligible == 2'b11) begin
        single_sel = rr_ptr_q;
      end else begin
        single_sel = eligible[1];
      end
      grant[single_sel] = 1'b1;
      mul_a = req_w8[single_sel] ? {8'h00, req_a[single_sel][7:0]} : req_a[single_sel];
      mul_b = req_w8[single_sel] ? {8'h00, req_b[single_sel][7:0]} : req_b[single_sel];
    end
  end

  // Response slots: capture on grant (even while draining), otherwise clear valid once drained
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_p_d     = rsp_p_q;
    rsp_tag_d   = rsp_tag_q;
    for (int r = 0; r < 2; r++) begin
      if (grant[r]) begin
        rsp_valid_d[r] = 1'b1;
        rsp_tag_d[r]   = req_tag[r];
        if (issue_kind == ISSUE_PAIR) begin
          rsp_p_d[r] = (r == 0) ? {16'h0000, mul_p[15:0]} : {16'h0000, mul_p[31:16]};
        end else begin
          rsp_p_d[r] = mul_p;
        end
      end else if (rsp_ready[r]) begin
        rsp_valid_d[r] = 1'b0;
      end
    end
  end

  // Round-robin pointer moves only on contended or paired issues; counters saturate
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    cnt_pair_d   = cnt_pair_q;
    cnt_single_d = cnt_single_q;
    if ((issue_kind == ISSUE_PAIR) || ((issue_kind == ISSUE_SINGLE) && (eligible == 2'b11))) begin
      rr_ptr_d = ~rr_ptr_q;
    end
    if ((issue_kind == ISSUE_PAIR) && (cnt_pair_q != {CNT_W{1'b1}})) begin
      cnt_pair_d = cnt_pair_q + CNT_W'(1);
    end
    if ((issue_kind == ISSUE_SINGLE) && (cnt_single_q != {CNT_W{1'b1}})) begin
      cnt_single_d = cnt_single_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_p_q      <= '0;
      rsp_tag_q    <= '0;
      cnt_pair_q   <= '0;
      cnt_single_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_p_q      <= rsp_p_d;
      rsp_tag_q    <= rsp_tag_d;
      cnt_pair_q   <= cnt_pair_d;
      cnt_single_q <= cnt_single_d;
    end
  end

  assign req_ready  = grant;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_p      = rsp_p_q;
  assign rsp_tag    = rsp_tag_q;
  assign cnt_pair   = cnt_pair_q;
  assign cnt_single = cnt_single_q;

endmodule

// File: tb/tb_var_bw_mul_sched.sv
// tb_var_bw_mul_sched: table-driven issue vectors plus directed round-robin,
// backpressure and reset sequences; a scoreboard checks every response.
module tb_var_bw_mul_sched;

  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic                  clk;
  logic                  rst_n;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0]            req_w8;
  logic [1:0][15:0]      req_a;
  logic [1:0][15:0]      req_b;
  logic [1:0][TAG_W-1:0] req_tag;
  logic                  mul_para_mode;
  logic [15:0]           mul_a;
  logic [15:0]           mul_b;
  logic [31:0]           mul_p;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [1:0][31:0]      rsp_p;
  logic [1:0][TAG_W-1:0] rsp_tag;
  logic [CNT_W-1:0]      cnt_pair;
  logic [CNT_W-1:0]      cnt_single;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]       valid;
    logic [1:0]       w8;
    logic [15:0]      a0;
    logic [15:0]      b0;
    logic [15:0]      a1;
    logic [15:0]      b1;
    logic [TAG_W-1:0] tag0;
    logic [TAG_W-1:0] tag1;
    logic [1:0]       exp_ready;
    logic             exp_para;
    logic [15:0]      exp_mula;
    logic [15:0]      exp_mulb;
    logic [31:0]      exp_p0;
    logic [31:0]      exp_p1;
  } vec_t;

  typedef struct {
    logic [31:0]      p;
    logic [TAG_W-1:0] tag;
  } sb_entry_t;

  vec_t      vecs [9];
  sb_entry_t sbq0 [$];
  sb_entry_t sbq1 [$];
  int        idx [2];

  var_bw_mul_sched #(.TAG_W(TAG_W), .PAIR_EN(1'b1), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_w8        (req_w8),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_tag       (req_tag),
    .mul_para_mode (mul_para_mode),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_p         (mul_p),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_p         (rsp_p),
    .rsp_tag       (rsp_tag),
    .cnt_pair      (cnt_pair),
    .cnt_single    (cnt_single)
  );

  // Shared multiplier model: one 16x16 product or two independent 8x8 products
  logic [15:0] prod_hi;
  logic [15:0] prod_lo;
  logic [31:0] prod_full;
  assign prod_hi   = {8'h00, mul_a[15:8]} * {8'h00, mul_b[15:8]};
  assign prod_lo   = {8'h00, mul_a[7:0]} * {8'h00, mul_b[7:0]};
  assign prod_full = {16'h0000, mul_a} * {16'h0000, mul_b};
  assign mul_p     = mul_para_mode ? {prod_hi, prod_lo} : prod_full;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] modelProduct(input logic w8, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] ea;
    logic [31:0] eb;
    ea = w8 ? {24'h0, a[7:0]} : {16'h0, a};
    eb = w8 ? {24'h0, b[7:0]} : {16'h0, b};
    return ea * eb;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_valid  = v.valid;
    req_w8     = v.w8;
    req_a[0]   = v.a0;
    req_b[0]   = v.b0;
    req_a[1]   = v.a1;
    req_b[1]   = v.b1;
    req_tag[0] = v.tag0;
    req_tag[1] = v.tag1;
  endtask

  task automatic applyIdle();
    req_valid = 2'b00;
    req_w8    = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
  endtask

  // Pop and compare drained responses, then push the expected result of each handshake
  task automatic scoreboardStep();
    sb_entry_t e;
    if (!rst_n) begin
      sbq0.delete();
      sbq1.delete();
      return;
    end
    for (int r = 0; r < 2; r++) begin
      if (rsp_valid[r] && rsp_ready[r]) begin
        if ((r == 0 && sbq0.size() == 0) || (r == 1 && sbq1.size() == 0)) begin
          checkOutput($sformatf("sb_unexpected_rsp%0d", r), 64'(rsp_valid[r]), 64'd0);
        end else begin
          if (r == 0) e = sbq0.pop_front();
          else        e = sbq1.pop_front();
          checkOutput($sformatf("sb_rsp_p%0d", r), 64'(rsp_p[r]), 64'(e.p));
          checkOutput($sformatf("sb_rsp_tag%0d", r), 64'(rsp_tag[r]), 64'(e.tag));
        end
      end
      if (req_valid[r] && req_ready[r]) begin
        e.p   = modelProduct(req_w8[r], req_a[r], req_b[r]);
        e.tag = req_tag[r];
        if (r == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
      end
    end
  endtask

  task automatic waitPos();
    @(posedge clk);
    #1;
  endtask

  task automatic waitNeg();
    @(negedge clk);
    scoreboardStep();
  endtask

  task automatic doReset();
    waitPos();
    rst_n = 1'b0;
    applyIdle();
    waitNeg();
    waitPos();
    rst_n = 1'b1;
    waitNeg();
  endtask

  task automatic checkResults(input vec_t v, input int i);
    checkOutput($sformatf("vec%0d_rsp_valid", i), 64'(rsp_valid), 64'(v.exp_ready));
    if (v.exp_ready[0]) checkOutput($sformatf("vec%0d_rsp_p0", i), 64'(rsp_p[0]), 64'(v.exp_p0));
    if (v.exp_ready[1]) checkOutput($sformatf("vec%0d_rsp_p1", i), 64'(rsp_p[1]), 64'(v.exp_p1));
  endtask

  initial begin
    // valid, w8, a0, b0, a1, b1, tag0, tag1, exp_ready, exp_para, exp_mula, exp_mulb, exp_p0, exp_p1
    vecs[0] = '{2'b01, 2'b00, 16'h1234, 16'h0010, 16'h0000, 16'h0000, 4'h1, 4'h0, 2'b01, 1'b0, 16'h1234, 16'h0010, 32'h0001_2340, 32'h0};
    vecs[1] = '{2'b11, 2'b11, 16'h00FF, 16'h00FF, 16'h000C, 16'h000B, 4'h2, 4'h3, 2'b11, 1'b1, 16'h0CFF, 16'h0BFF, 32'h0000_FE01, 32'h0000_0084};
    vecs[2] = '{2'b11, 2'b00, 16'h0003, 16'h0004, 16'h0100, 16'h0100, 4'h4, 4'h5, 2'b10, 1'b0, 16'h0100, 16'h0100, 32'h0, 32'h0001_0000};
    vecs[3] = '{2'b01, 2'b00, 16'h0003, 16'h0004, 16'h0000, 16'h0000, 4'h4, 4'h0, 2'b01, 1'b0, 16'h0003, 16'h0004, 32'h0000_000C, 32'h0};
    vecs[4] = '{2'b10, 2'b10, 16'h0000, 16'h0000, 16'hAB07, 16'hCD09, 4'h0, 4'h6, 2'b10, 1'b0, 16'h0007, 16'h0009, 32'h0, 32'h0000_003F};
    vecs[5] = '{2'b11, 2'b01, 16'h1203, 16'h0005, 16'hFFFF, 16'hFFFF, 4'h7, 4'h8, 2'b01, 1'b0, 16'h0003, 16'h0005, 32'h0000_000F, 32'h0};
    vecs[6] = '{2'b10, 2'b00, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 4'h0, 4'h8, 2'b10, 1'b0, 16'hFFFF, 16'hFFFF, 32'h0, 32'hFFFE_0001};
    vecs[7] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 2'b00, 1'b0, 16'h0000, 16'h0000, 32'h0, 32'h0};
    vecs[8] = '{2'b11, 2'b11, 16'h1280, 16'h3402, 16'h56FF, 16'h7801, 4'h9, 4'hA, 2'b11, 1'b1, 16'hFF80, 16'h0102, 32'h0000_0100, 32'h0000_00FF};

    // Reset state, with requests already presented to prove ready is held low
    rst_n     = 1'b0;
    applyIdle();
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    waitNeg();
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_mul_a", 64'(mul_a), 64'd0);
    checkOutput("rst_mul_b", 64'(mul_b), 64'd0);
    checkOutput("rst_para", 64'(mul_para_mode), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rsp_p", 64'(rsp_p), 64'd0);
    checkOutput("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    checkOutput("rst_cnt_pair", 64'(cnt_pair), 64'd0);
    checkOutput("rst_cnt_single", 64'(cnt_single), 64'd0);
    waitPos();
    rst_n     = 1'b1;
    applyIdle();
    rsp_ready = 2'b11;
    waitNeg();

    // Table-driven issue vectors with responses always drained
    for (int i = 0; i < 9; i++) begin
      waitPos();
      if (i > 0) checkResults(vecs[i-1], i - 1);
      applyStimulus(vecs[i]);
      waitNeg();
      checkOutput($sformatf("vec%0d_req_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
      checkOutput($sformatf("vec%0d_para", i), 64'(mul_para_mode), 64'(vecs[i].exp_para));
      checkOutput($sformatf("vec%0d_mul_a", i), 64'(mul_a), 64'(vecs[i].exp_mula));
      checkOutput($sformatf("vec%0d_mul_b", i), 64'(mul_b), 64'(vecs[i].exp_mulb));
    end
    waitPos();
    checkResults(vecs[8], 8);
    applyIdle();
    waitNeg();
    checkOutput("table_cnt_single", 64'(cnt_single), 64'd6);
    checkOutput("table_cnt_pair", 64'(cnt_pair), 64'd2);

    // Two continuously valid 16-bit requesters must alternate grants starting at 0
    doReset();
    idx[0] = 0;
    idx[1] = 0;
    for (int k = 0; k < 6; k++) begin
      waitPos();
      req_valid = 2'b11;
      req_w8    = 2'b00;
      for (int r = 0; r < 2; r++) begin
        req_a[r]   = 16'(16'h1000 * (r + 1) + idx[r]);
        req_b[r]   = 16'(idx[r] + 2);
        req_tag[r] = TAG_W'(idx[r]);
      end
      waitNeg();
      checkOutput($sformatf("rr_grant%0d", k), 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      for (int r = 0; r < 2; r++) if (req_ready[r]) idx[r]++;
    end
    waitPos();
    applyIdle();
    waitNeg();
    checkOutput("rr_cnt_single", 64'(cnt_single), 64'd6);
    checkOutput("rr_cnt_pair", 64'(cnt_pair), 64'd0);
    checkOutput("rr_results0", 64'(idx[0]), 64'd3);
    checkOutput("rr_results1", 64'(idx[1]), 64'd3);

    // Backpressure: full slot blocks a new request until drained, then same-cycle refill
    waitPos();
    rsp_ready  = 2'b00;
    req_valid  = 2'b01;
    req_w8     = 2'b00;
    req_a[0]   = 16'h0002;
    req_b[0]   = 16'h0003;
    req_tag[0] = 4'hB;
    waitNeg();
    checkOutput("bp_accept", 64'(req_ready), 64'd1);
    waitPos();
    checkOutput("bp_first_valid", 64'(rsp_valid[0]), 64'd1);
    checkOutput("bp_first_p", 64'(rsp_p[0]), 64'd6);
    req_a[0]   = 16'h0005;
    req_b[0]   = 16'h0007;
    req_tag[0] = 4'hC;
    waitNeg();
    checkOutput("bp_stall", 64'(req_ready), 64'd0);
    waitPos();
    checkOutput("bp_hold_p", 64'(rsp_p[0]), 64'd6);
    checkOutput("bp_hold_valid", 64'(rsp_valid[0]), 64'd1);
    rsp_ready = 2'b01;
    waitNeg();
    checkOutput("bp_release", 64'(req_ready), 64'd1);
    waitPos();
    checkOutput("bp_refill_p", 64'(rsp_p[0]), 64'd35);
    checkOutput("bp_refill_tag", 64'(rsp_tag[0]), 64'hC);
    checkOutput("bp_refill_valid", 64'(rsp_valid[0]), 64'd1);
    req_valid = 2'b00;
    waitNeg();
    waitPos();
    checkOutput("bp_drained", 64'(rsp_valid), 64'd0);

    // Reset mid-operation with both slots full and both requests pending
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    req_w8    = 2'b00;
    req_a[0]  = 16'h0011;
    req_b[0]  = 16'h0002;
    req_a[1]  = 16'h0021;
    req_b[1]  = 16'h0003;
    req_tag   = '0;
    waitNeg();
    checkOutput("mid_first_grant", 64'(req_ready), 64'd1);
    waitPos();
    waitNeg();
    checkOutput("mid_second_grant", 64'(req_ready), 64'd2);
    waitPos();
    waitNeg();
    checkOutput("mid_full_valid", 64'(rsp_valid), 64'd3);
    checkOutput("mid_full_ready", 64'(req_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_async_valid", 64'(rsp_valid), 64'd0);
    checkOutput("mid_async_cnt_single", 64'(cnt_single), 64'd0);
    checkOutput("mid_async_rsp_p", 64'(rsp_p), 64'd0);
    checkOutput("mid_async_ready", 64'(req_ready), 64'd0);
    waitPos();
    waitNeg();
    waitPos();
    rst_n     = 1'b1;
    rsp_ready = 2'b11;
    waitNeg();
    checkOutput("mid_post_grant", 64'(req_ready), 64'd1);
    checkOutput("mid_post_mul_a", 64'(mul_a), 64'h0011);
    waitPos();
    waitNeg();
    checkOutput("mid_post_grant2", 64'(req_ready), 64'd2);
    waitPos();
    applyIdle();
    waitNeg();
    waitPos();
    waitNeg();
    checkOutput("sb_left0", 64'(sbq0.size()), 64'd0);
    checkOutput("sb_left1", 64'(sbq1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
